input_debouncer: RTL and testbench

Single-clock debounce and edge-detect stage that sits directly downstream of `synchronizer` and consumes its `out`. It accepts a level that is already in the `clk` domain and suppresses glitches shorter than `STABLE_CYCLES`. It then presents a clean registered level plus one-cycle rise and fall strobes to control logic such as button handlers, mode pins and external enables.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/input_debouncer_sat_counter.sv | 25 ++
 rtl/input_debouncer.sv | 135 +++++++++++++
 tb/tb_input_debouncer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer: FSM state encoding,
// stability-counter width and the default glitch-counter width.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

   localparam int GLITCH_W_DEFAULT = 8;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/input_debouncer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != {W{1'b1}}))
         r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/input_debouncer.sv
// Debounce and edge-detect for a level already synchronized to clk.
// Optional rejected-transition counter: define INPUT_DEBOUNCER_GLITCH_COUNT_EN.
//
//   state       | meaning
//   S_LOW       | level 0, input agrees
//   S_WAIT_HIGH | level 0, input high, counting stable samples
//   S_HIGH      | level 1, input agrees
//   S_WAIT_LOW  | level 1, input low, counting stable samples
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int   STABLE_CYCLES = 16,
   parameter logic INIT          = 1'b0,
   parameter int   GLITCH_W      = GLITCH_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in,
   output logic                level,
   output logic                rise,
   output logic                fall
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   localparam int            CW        = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST      = CW'(STABLE_CYCLES - 1);
   localparam state_t        RST_STATE = INIT ? S_HIGH : S_LOW;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   logic          w_level_nxt;
   logic          w_glitch;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_glitch    = 1'b0;
      case (r_state)
         S_LOW: begin
            if (in) begin
               if (STABLE_CYCLES == 1) begin
                  w_state_nxt = S_HIGH;
               end else begin
                  w_state_nxt = S_WAIT_HIGH;
                  w_cnt_nxt   = CW'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (!in) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = '0;
               w_glitch    = 1'b1;
            end else if (r_cnt == LAST) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_HIGH: begin
            if (!in) begin
               if (STABLE_CYCLES == 1) begin
                  w_state_nxt = S_LOW;
               end else begin
                  w_state_nxt = S_WAIT_LOW;
                  w_cnt_nxt   = CW'(1);
               end
            end
         end
         S_WAIT_LOW: begin
            if (in) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
               w_glitch    = 1'b1;
            end else if (r_cnt == LAST) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = RST_STATE;
            w_cnt_nxt   = '0;
         end
      endcase
      w_level_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_WAIT_LOW);
   end

   // Strobes are registered alongside level so they coincide with its first new cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RST_STATE;
         r_cnt   <= '0;
         r_level <= INIT;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_level_nxt & ~r_level;
         r_fall  <= ~w_level_nxt & r_level;
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;

`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
   sat_counter #(
      .W(GLITCH_W)
   ) u_glitch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (1'b0),
      .i_inc (w_glitch),
      .o_cnt (glitch_cnt)
   );
`else
   logic w_glitch_unused;
   assign w_glitch_unused = w_glitch;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: a 16-cycle instance (GLITCH_W=2) and a 1-cycle instance.
module tb_input_debouncer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst1_n, in16, in1;
   logic level16, rise16, fall16, level1, rise1, fall1;
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
   logic [1:0] gl16;
   logic [7:0] gl1;
`endif

   input_debouncer #(.STABLE_CYCLES(16), .INIT(1'b0), .GLITCH_W(2)) dut16 (
      .clk(clk), .rst_n(rst_n), .in(in16),
      .level(level16), .rise(rise16), .fall(fall16)
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
      , .glitch_cnt(gl16)
`endif
   );

   input_debouncer #(.STABLE_CYCLES(1), .INIT(1'b0), .GLITCH_W(8)) dut1 (
      .clk(clk), .rst_n(rst1_n), .in(in1),
      .level(level1), .rise(rise1), .fall(fall1)
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
      , .glitch_cnt(gl1)
`endif
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   c;
      logic lv;
      logic r;
      logic f;
      int   g;
   } exp_t;

   exp_t q16[$];
   exp_t q1[$];
   exp_t e16, e1;
   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, c, act, exp);
      end
   endtask

   function automatic void push16(input int c, input logic lv, input logic r, input logic f, input int g);
      exp_t e;
      e = '{c, lv, r, f, g};
      q16.push_back(e);
   endfunction

   function automatic void push1(input int c, input logic lv, input logic r, input logic f, input int g);
      exp_t e;
      e = '{c, lv, r, f, g};
      q1.push_back(e);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      while (q16.size() > 0 && q16[0].c < cyc) begin
         e16 = q16.pop_front();
         check("dut16 missed sample", cyc, e16.c, cyc);
      end
      if (q16.size() > 0 && q16[0].c == cyc) begin
         e16 = q16.pop_front();
         check("dut16 level", level16, e16.lv, cyc);
         check("dut16 rise", rise16, e16.r, cyc);
         check("dut16 fall", fall16, e16.f, cyc);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
         if (e16.g >= 0) check("dut16 glitch_cnt", gl16, e16.g, cyc);
`endif
      end else if (rise16 || fall16) begin
         check("dut16 unexpected strobe", {rise16, fall16}, 0, cyc);
      end
   end

   always @(negedge clk) begin
      while (q1.size() > 0 && q1[0].c < cyc) begin
         e1 = q1.pop_front();
         check("dut1 missed sample", cyc, e1.c, cyc);
      end
      if (q1.size() > 0 && q1[0].c == cyc) begin
         e1 = q1.pop_front();
         check("dut1 level", level1, e1.lv, cyc);
         check("dut1 rise", rise1, e1.r, cyc);
         check("dut1 fall", fall1, e1.f, cyc);
`ifdef INPUT_DEBOUNCER_GLITCH_COUNT_EN
         if (e1.g >= 0) check("dut1 glitch_cnt", gl1, e1.g, cyc);
`endif
      end else if (rise1 || fall1) begin
         check("dut1 unexpected strobe", {rise1, fall1}, 0, cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int v1[8] = '{1, 0, 1, 0, 1, 1, 0, 0};
   int r1[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
   int f1[8] = '{0, 1, 0, 1, 0, 0, 1, 0};
   int gexp[5] = '{1, 2, 3, 3, 3};
   int b, b2;

   initial begin
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      in16   = 1'b1;
      in1    = 1'b0;
      step(3);

      // STABLE_CYCLES=1: level follows in by one register, strobe on every change
      push1(cyc, 0, 0, 0, 0);
      rst1_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in1 = v1[i][0];
         push1(cyc + 1, v1[i][0], r1[i][0], f1[i][0], 0);
         step(1);
      end
      push1(cyc + 1, 0, 0, 0, 0);
      step(2);

      // Reset held with in=1: level stays INIT, then rises 16 edges after release
      b = cyc;
      push16(b, 0, 0, 0, 0);
      rst_n = 1'b1;
      push16(b + 1, 0, 0, 0, 0);
      push16(b + 15, 0, 0, 0, 0);
      push16(b + 16, 1, 1, 0, 0);
      push16(b + 17, 1, 0, 0, 0);
      step(20);

      b = cyc;
      in16 = 1'b0;
      push16(b + 15, 1, 0, 0, 0);
      push16(b + 16, 0, 0, 1, 0);
      push16(b + 17, 0, 0, 0, 0);
      step(20);

      // 15-sample pulse is rejected and counted as a glitch
      b = cyc;
      in16 = 1'b1;
      push16(b + 8, 0, 0, 0, 0);
      push16(b + 15, 0, 0, 0, 0);
      step(15);
      in16 = 1'b0;
      push16(b + 16, 0, 0, 0, 1);
      push16(b + 17, 0, 0, 0, 1);
      step(20);

      // 16-sample pulse is accepted: rise and fall exactly 16 cycles apart
      b = cyc;
      in16 = 1'b1;
      push16(b + 15, 0, 0, 0, 1);
      push16(b + 16, 1, 1, 0, 1);
      push16(b + 17, 1, 0, 0, 1);
      step(16);
      in16 = 1'b0;
      push16(b + 31, 1, 0, 0, 1);
      push16(b + 32, 0, 0, 1, 1);
      push16(b + 33, 0, 0, 0, 1);
      step(40);

      // Reset at count 10 of a wait: partial count discarded, restarts after release
      b = cyc;
      in16 = 1'b1;
      step(10);
      rst_n = 1'b0;
      push16(cyc, 0, 0, 0, 0);
      step(3);
      b2 = cyc;
      rst_n = 1'b1;
      push16(b2 + 1, 0, 0, 0, 0);
      push16(b2 + 15, 0, 0, 0, 0);
      push16(b2 + 16, 1, 1, 0, 0);
      push16(b2 + 17, 1, 0, 0, 0);
      step(20);
      b = cyc;
      in16 = 1'b0;
      push16(b + 15, 1, 0, 0, 0);
      push16(b + 16, 0, 0, 1, 0);
      step(20);

      // Five short glitches: the 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         b = cyc;
         in16 = 1'b1;
         step(3);
         in16 = 1'b0;
         push16(b + 4, 0, 0, 0, gexp[i]);
         step(3);
      end
      step(5);

      check("dut16 leftover expectations", q16.size(), 0, cyc);
      check("dut1 leftover expectations", q1.size(), 0, cyc);
      $display("%0d/%0d checks passed", checks - errors, checks);
      $finish;
   end

endmodule
